// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern loader: FSM state encoding and default
// chain geometry / serial clock timing.
package pattern_pkg;

  localparam int NBYTES_DEFAULT = 27;
  localparam int HALF_DEFAULT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // True while a bit is on the wire (either half of sclk)
  function automatic logic is_shifting(state_e s);
    return (s == ST_LOW) || (s == ST_HIGH);
  endfunction

endpackage

// File: rtl/pattern_loader_if.sv
// Byte feed, serial chain and status signals of the pattern loader.
interface pattern_loader_if;

  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       sout_in;
  logic       sclk_out;
  logic       ssel_out;
  logic       sin_out;
  logic [7:0] rb_byte;
  logic       rb_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, byte_in, byte_valid, sout_in,
    input  byte_ready, sclk_out, ssel_out, sin_out, rb_byte, rb_valid, busy, done
  );

  modport slave (
    input  start, byte_in, byte_valid, sout_in,
    output byte_ready, sclk_out, ssel_out, sin_out, rb_byte, rb_valid, busy, done
  );

endinterface

// File: rtl/sclk_divider.sv
// Phase counter for the serial clock: tick_o marks the last clk cycle of
// each HALF-cycle sclk phase while enabled.
module sclk_divider #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == 4'(HALF - 1));
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// Serial loader for a daisy-chained pattern buffer: shifts NBYTES bytes out
// MSB first while capturing the chain's previous contents as readback bytes.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT,
  parameter int HALF   = HALF_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  pattern_loader_if.slave bus
);

  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  state_e         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rbsh_q, rbsh_d;
  logic [7:0]     rb_byte_q, rb_byte_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           sclk_q, sclk_d, ssel_q, ssel_d, sin_q, sin_d;
  logic           ready_q, ready_d, rb_valid_q, rb_valid_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           phase_end, accept, bit_end;

  sclk_divider #(.HALF(HALF)) u_div (
    .clk    (clk),
    .reset  (reset),
    .en_i   (is_shifting(state_q)),
    .tick_o (phase_end)
  );

  assign accept  = (state_q == ST_FETCH) && bus.byte_valid;
  assign bit_end = (state_q == ST_HIGH) && phase_end && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_FETCH;
      ST_FETCH:  if (bus.byte_valid) state_d = ST_LOW;
      ST_LOW:    if (phase_end) state_d = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          if (bit_cnt_q != 3'd7) begin
            state_d = ST_LOW;
          end else if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pin is a flop
  always_comb begin
    shift_d    = shift_q;
    rbsh_d     = rbsh_q;
    rb_byte_d  = rb_byte_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rb_valid_d = 1'b0;
    if ((state_q == ST_IDLE) && bus.start) begin
      byte_cnt_d = '0;
    end
    if (accept) begin
      shift_d   = bus.byte_in;
      bit_cnt_d = 3'd0;
    end
    // sclk rises on this edge: capture the chain's outgoing bit
    if ((state_q == ST_LOW) && phase_end) begin
      rbsh_d = {rbsh_q[6:0], bus.sout_in};
    end
    if ((state_q == ST_HIGH) && phase_end) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (bit_end) begin
      rb_byte_d  = rbsh_q;
      rb_valid_d = 1'b1;
      if (byte_cnt_q != LAST_BYTE) begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
      end
    end
    sclk_d  = (state_d == ST_HIGH);
    ssel_d  = (state_d == ST_FETCH) || is_shifting(state_d);
    sin_d   = is_shifting(state_d) ? shift_d[7] : 1'b0;
    ready_d = (state_d == ST_FETCH);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      rbsh_q     <= '0;
      rb_byte_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rb_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      ssel_q     <= 1'b0;
      sin_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      rbsh_q     <= rbsh_d;
      rb_byte_q  <= rb_byte_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rb_valid_q <= rb_valid_d;
      sclk_q     <= sclk_d;
      ssel_q     <= ssel_d;
      sin_q      <= sin_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sclk_out   = sclk_q;
  assign bus.ssel_out   = ssel_q;
  assign bus.sin_out    = sin_q;
  assign bus.byte_ready = ready_q;
  assign bus.rb_byte    = rb_byte_q;
  assign bus.rb_valid   = rb_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: behavioural buffer chain, readback scoreboard,
// and two small instances exercising the sclk timing at HALF=1 and HALF=4.
module tb_pattern_loader;

  localparam int NB       = 27;
  localparam int H        = 2;
  localparam int EXP_DONE = 1 + NB * (1 + 16 * H);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_loader_if ifc();
  pattern_loader #(.NBYTES(NB), .HALF(H)) dut (.clk(clk), .reset(rst), .bus(ifc));

  // Downstream chain: byte i bit 7 feeds byte i+1 bit 0; sout is the last byte's MSB
  logic [8*NB-1:0] chain;
  logic [8*NB-1:0] preload_val = '0;
  logic            preload_req = 1'b0;
  int              edge_cnt = 0;

  assign ifc.sout_in = chain[8*NB-1];

  always @(posedge ifc.sclk_out or posedge preload_req) begin
    if (preload_req) begin
      chain <= preload_val;
    end else begin
      chain    <= {chain[8*NB-2:0], ifc.sin_out};
      edge_cnt <= edge_cnt + 1;
    end
  end

  logic [7:0] pat [NB];
  logic [7:0] rb_exp [$];
  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, rb_seen = 0, ssel_bad = 0;
  int stall_bad = 0, stall_e0 = 0, stall_e1 = 0;

  // Two extra instances for serial clock timing
  logic start_h = 1'b0;
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_h
    localparam int HH = (gi == 0) ? 1 : 4;
    pattern_loader_if hif();
    assign hif.start      = start_h;
    assign hif.byte_in    = 8'h96;
    assign hif.byte_valid = 1'b1;
    assign hif.sout_in    = 1'b0;
    pattern_loader #(.NBYTES(2), .HALF(HH)) u_dut (.clk(clk), .reset(rst), .bus(hif));

    int   cyc = 0, last_rise = 0, rise_cnt = 0, hcnt = 0;
    int   hi_bad = 0, per_bad = 0, per_chk = 0, sin_bad = 0, first_per = 0;
    logic prev_sclk = 1'b0, prev_sin = 1'b0;

    always @(posedge clk) begin
      cyc       <= cyc + 1;
      prev_sclk <= hif.sclk_out;
      prev_sin  <= hif.sin_out;
      if (hif.sclk_out === 1'b1 && hif.sin_out !== prev_sin) sin_bad <= sin_bad + 1;
      if (hif.sclk_out === 1'b1 && prev_sclk === 1'b0) begin
        rise_cnt  <= rise_cnt + 1;
        last_rise <= cyc;
        if (rise_cnt % 8 != 0) begin
          per_chk <= per_chk + 1;
          if (cyc - last_rise != 2 * HH) per_bad <= per_bad + 1;
          if (rise_cnt == 1) first_per <= cyc - last_rise;
        end
      end
      if (hif.sclk_out === 1'b1) begin
        hcnt <= hcnt + 1;
      end else begin
        if (prev_sclk === 1'b1 && hcnt != HH) hi_bad <= hi_bad + 1;
        hcnt <= 0;
      end
    end
  end

  task automatic preload(input logic [8*NB-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    #1;
    preload_req = 1'b0;
  endtask

  // Runs one load from a negedge; compares readback against the scoreboard
  task automatic do_load(input bit push_model, input int stall_idx, input int stall_len,
                         input int start_at, input int stop_edges, output int done_cyc);
    int idx, stall_rem, cyc, e0;
    bit fin;
    logic [7:0] exp_b;
    idx = 0; stall_rem = stall_len; cyc = 0; fin = 1'b0; done_cyc = -1; e0 = edge_cnt;
    if (push_model) begin
      rb_exp.delete();
      for (int k = 0; k < NB; k++) rb_exp.push_back(chain[8*(NB-1-k) +: 8]);
    end
    ifc.start = 1'b1;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ifc.start = (cyc == start_at);
      if (ifc.busy === 1'b1 && ifc.done !== 1'b1 && ifc.ssel_out !== 1'b1) ssel_bad++;
      if (ifc.rb_valid === 1'b1) begin
        rb_seen++;
        n_cmp++;
        if (rb_exp.size() == 0) begin
          n_bad++;
          $display("FAIL rb_extra: rb_byte=%02h with no expected byte left", ifc.rb_byte);
        end else begin
          exp_b = rb_exp.pop_front();
          if (ifc.rb_byte !== exp_b) begin
            n_bad++;
            $display("FAIL rb_byte: got %02h expected %02h", ifc.rb_byte, exp_b);
          end else begin
            $display("rb_byte %02h ok", ifc.rb_byte);
          end
        end
      end
      if (ifc.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      if (stop_edges > 0 && edge_cnt - e0 >= stop_edges) fin = 1'b1;
      if (ifc.byte_ready === 1'b1 && idx < NB) begin
        if (idx == stall_idx && stall_rem > 0) begin
          if (stall_rem == stall_len) stall_e0 = edge_cnt;
          ifc.byte_valid = 1'b0;
          if (ifc.sclk_out !== 1'b0) stall_bad++;
          stall_rem--;
        end else begin
          if (idx == stall_idx && stall_len > 0) stall_e1 = edge_cnt;
          ifc.byte_valid = 1'b1;
          ifc.byte_in    = pat[idx];
          idx++;
        end
      end else begin
        ifc.byte_valid = 1'b0;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: no done after %0d cycles, required done", cyc);
    end
    ifc.start      = 1'b0;
    ifc.byte_valid = 1'b0;
  endtask

  task automatic check_pattern(input string name);
    logic [8*NB-1:0] exp_v;
    for (int i = 0; i < NB; i++) exp_v[8*i +: 8] = pat[NB-1-i];
    n_cmp++;
    if (chain !== exp_v) begin
      n_bad++;
      $display("FAIL %s: buffer %h expected %h", name, chain, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [8*NB-1:0] r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ifc.sclk_out, ifc.ssel_out, ifc.sin_out, ifc.byte_ready, ifc.rb_valid, ifc.busy, ifc.done} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: outputs %b expected 0000000", {ifc.sclk_out, ifc.ssel_out,
               ifc.sin_out, ifc.byte_ready, ifc.rb_valid, ifc.busy, ifc.done});
    end
    n_cmp++;
    if (ifc.rb_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_rb: rb_byte %02h expected 00", ifc.rb_byte);
    end
    for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    preload(r);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ifc.busy !== 1'b0 || ifc.byte_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b ready=%b expected 0 0", ifc.busy, ifc.byte_ready);
    end
    $display("reset sequence complete");
  endtask

  task automatic test_full_load();
    int d0, r0, e0, dc, extra;
    for (int i = 0; i < NB; i++) pat[i] = 8'(i);
    d0 = done_cnt; r0 = rb_seen; e0 = edge_cnt; ssel_bad = 0;
    do_load(1'b1, -1, 0, 0, 0, dc);
    n_cmp++;
    if (edge_cnt - e0 != 216) begin n_bad++; $display("FAIL full_edges: %0d expected 216", edge_cnt - e0); end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL full_done: %0d pulses expected 1", done_cnt - d0); end
    n_cmp++;
    if (dc != EXP_DONE) begin n_bad++; $display("FAIL full_done_time: cycle %0d expected %0d", dc, EXP_DONE); end
    n_cmp++;
    if (rb_seen - r0 != NB || rb_exp.size() != 0) begin
      n_bad++;
      $display("FAIL full_rb_count: %0d pulses, %0d left, expected %0d and 0", rb_seen - r0, rb_exp.size(), NB);
    end
    n_cmp++;
    if (ssel_bad != 0) begin n_bad++; $display("FAIL full_ssel: %0d low cycles while busy, expected 0", ssel_bad); end
    for (int i = 0; i < NB; i++) begin
      n_cmp++;
      if (chain[8*i +: 8] !== 8'(32'h1A - i)) begin
        n_bad++;
        $display("FAIL full_byte%0d: %02h expected %02h", i, chain[8*i +: 8], 8'(32'h1A - i));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.ssel_out !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      n_bad++;
      $display("FAIL full_after: ssel=%b busy=%b done=%b expected 0 0 0", ifc.ssel_out, ifc.busy, ifc.done);
    end
    extra = 0;
    repeat (5) begin @(negedge clk); if (ifc.done === 1'b1) extra++; end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL full_done_extra: %0d extra pulses expected 0", extra); end
    $display("full load complete, done at cycle %0d", dc);
  endtask

  task automatic test_readback();
    logic [8*NB-1:0] v;
    int r0, dc;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = 8'(8'hA0 + i);
    preload(v);
    for (int i = 0; i < NB; i++) pat[i] = 8'h55;
    rb_exp.delete();
    for (int k = 0; k < NB; k++) rb_exp.push_back(8'(8'hBA - k));
    r0 = rb_seen;
    do_load(1'b0, -1, 0, 0, 0, dc);
    n_cmp++;
    if (rb_seen - r0 != 27 || rb_exp.size() != 0) begin
      n_bad++;
      $display("FAIL rb_count: %0d pulses, %0d left, expected 27 and 0", rb_seen - r0, rb_exp.size());
    end
    n_cmp++;
    if (chain !== {NB{8'h55}}) begin n_bad++; $display("FAIL rb_buffer: %h expected all 55", chain); end
    @(negedge clk);
    $display("readback load complete");
  endtask

  task automatic test_stall();
    logic [8*NB-1:0] r;
    int e0, dc;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    preload(r);
    for (int i = 0; i < NB; i++) pat[i] = 8'(i);
    stall_bad = 0; stall_e0 = -1; stall_e1 = -2; e0 = edge_cnt;
    do_load(1'b1, 5, 10, 0, 0, dc);
    n_cmp++;
    if (stall_bad != 0) begin n_bad++; $display("FAIL stall_sclk: %0d high cycles expected 0", stall_bad); end
    n_cmp++;
    if (stall_e1 != stall_e0) begin n_bad++; $display("FAIL stall_edges: %0d edges during stall expected 0", stall_e1 - stall_e0); end
    n_cmp++;
    if (edge_cnt - e0 != 216) begin n_bad++; $display("FAIL stall_total_edges: %0d expected 216", edge_cnt - e0); end
    n_cmp++;
    if (dc != EXP_DONE + 10) begin n_bad++; $display("FAIL stall_done_time: %0d expected %0d", dc, EXP_DONE + 10); end
    check_pattern("stall_buffer");
    @(negedge clk);
    $display("stalled load complete");
  endtask

  task automatic test_abort();
    int dc, ea, e0, d0;
    for (int i = 0; i < NB; i++) pat[i] = 8'(i * 7 + 3);
    do_load(1'b1, -1, 0, 0, 100, dc);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ifc.sclk_out, ifc.ssel_out, ifc.sin_out, ifc.byte_ready, ifc.rb_valid, ifc.busy, ifc.done} !== 7'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: %b expected 0000000", {ifc.sclk_out, ifc.ssel_out,
               ifc.sin_out, ifc.byte_ready, ifc.rb_valid, ifc.busy, ifc.done});
    end
    n_cmp++;
    if (ifc.rb_byte !== 8'h00) begin n_bad++; $display("FAIL abort_rb: %02h expected 00", ifc.rb_byte); end
    ea = edge_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (edge_cnt != ea || ifc.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet: %0d edges busy=%b after reset, expected 0 and 0", edge_cnt - ea, ifc.busy);
    end
    for (int i = 0; i < NB; i++) pat[i] = 8'(i) ^ 8'h3C;
    e0 = edge_cnt; d0 = done_cnt;
    do_load(1'b1, -1, 0, 0, 0, dc);
    n_cmp++;
    if (edge_cnt - e0 != 216 || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL reload_counts: %0d edges %0d done, expected 216 and 1", edge_cnt - e0, done_cnt - d0);
    end
    check_pattern("reload_buffer");
    @(negedge clk);
    $display("abort and reload complete");
  endtask

  task automatic test_start_ignored();
    int e0, d0, dc;
    for (int i = 0; i < NB; i++) pat[i] = 8'(255 - i);
    e0 = edge_cnt; d0 = done_cnt;
    do_load(1'b1, -1, 0, 34, 0, dc);
    n_cmp++;
    if (dc != EXP_DONE) begin n_bad++; $display("FAIL busy_start_time: done at %0d expected %0d", dc, EXP_DONE); end
    n_cmp++;
    if (edge_cnt - e0 != 216 || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL busy_start_counts: %0d edges %0d done, expected 216 and 1", edge_cnt - e0, done_cnt - d0);
    end
    check_pattern("busy_start_buffer");
    @(negedge clk);
    $display("start while busy ignored");
  endtask

  task automatic test_half();
    int cyc;
    bit d0, d1;
    d0 = 1'b0; d1 = 1'b0; cyc = 0;
    start_h = 1'b1;
    @(negedge clk);
    start_h = 1'b0;
    while (!(d0 && d1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (g_h[0].hif.done === 1'b1) d0 = 1'b1;
      if (g_h[1].hif.done === 1'b1) d1 = 1'b1;
    end
    n_cmp++;
    if (!(d0 && d1)) begin n_bad++; $display("FAIL half_timeout: done1=%b done4=%b expected 1 1", d0, d1); end
    n_cmp++;
    if (g_h[0].rise_cnt != 16 || g_h[0].per_chk != 14 || g_h[0].per_bad != 0) begin
      n_bad++;
      $display("FAIL half1_period: rises=%0d checked=%0d bad=%0d expected 16 14 0",
               g_h[0].rise_cnt, g_h[0].per_chk, g_h[0].per_bad);
    end
    n_cmp++;
    if (g_h[0].first_per != 2 || g_h[0].hi_bad != 0 || g_h[0].sin_bad != 0) begin
      n_bad++;
      $display("FAIL half1_shape: period=%0d hi_bad=%0d sin_bad=%0d expected 2 0 0",
               g_h[0].first_per, g_h[0].hi_bad, g_h[0].sin_bad);
    end
    n_cmp++;
    if (g_h[1].rise_cnt != 16 || g_h[1].per_chk != 14 || g_h[1].per_bad != 0) begin
      n_bad++;
      $display("FAIL half4_period: rises=%0d checked=%0d bad=%0d expected 16 14 0",
               g_h[1].rise_cnt, g_h[1].per_chk, g_h[1].per_bad);
    end
    n_cmp++;
    if (g_h[1].first_per != 8 || g_h[1].hi_bad != 0 || g_h[1].sin_bad != 0) begin
      n_bad++;
      $display("FAIL half4_shape: period=%0d hi_bad=%0d sin_bad=%0d expected 8 0 0",
               g_h[1].first_per, g_h[1].hi_bad, g_h[1].sin_bad);
    end
    $display("sclk timing loads complete after %0d cycles", cyc);
  endtask

  initial begin
    ifc.start      = 1'b0;
    ifc.byte_in    = 8'h00;
    ifc.byte_valid = 1'b0;
    test_reset();
    test_full_load();
    test_readback();
    test_stall();
    test_abort();
    test_start_ignored();
    test_half();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 Parameter NBYTES, default 27: number of bytes in the downstream pattern buffer chain.
REQ-002 Parameter HALF, default 2: sclk_out half-period in clk cycles, legal range 1..15.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a full load; honoured only in IDLE.
REQ-006 byte_in  input  8  next pattern byte to transmit.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 sout_in  input  1  serial return bit from the buffer chain (last byte, bit 7).
REQ-010 sclk_out  output  1  serial shift clock to the buffer chain.
REQ-011 ssel_out  output  1  serial select to the buffer chain.
REQ-012 sin_out  output  1  serial data to the buffer chain.
REQ-013 rb_byte  output  8  readback byte (previous buffer contents).
REQ-014 rb_valid  output  1  one-cycle strobe qualifying rb_byte.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle strobe at the end of a complete load.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, LOW, HIGH and FINISH.
REQ-018 IDLE: start=1 -> FETCH, clears byte counter; start in any other state SHALL be ignored.
REQ-019 FETCH: byte_ready=1; byte_valid=1 -> latch byte_in into an 8-bit shift register, bit counter=0, -> LOW; byte_ready SHALL be 0 in all other states.
REQ-020 LOW: sclk_out=0, sin_out=shift register bit 7, held HALF cycles, -> HIGH.
REQ-021 HIGH: sclk_out=1, held HALF cycles; sin_out SHALL be stable throughout LOW and HIGH of a bit.
REQ-022 On the clk edge where sclk_out goes 0->1, sout_in SHALL be sampled and shifted into the readback register LSB-first (left shift).
REQ-023 End of HIGH: shift register shifts left by one; bit counter<7 -> LOW; bit counter=7 -> rb_valid pulse with the completed rb_byte, then byte counter=NBYTES-1 -> FINISH, else increment -> FETCH.
REQ-024 Bytes SHALL be transmitted MSB first; the first accepted byte ends in buffer byte NBYTES-1, the last in byte 0.
REQ-025 The k-th rb_byte (k=0..NBYTES-1) SHALL equal the old contents of buffer byte NBYTES-1-k.
REQ-026 ssel_out SHALL be 1 from entry to FETCH after start until FINISH, else 0.
REQ-027 sclk_out SHALL be 0 in IDLE, FETCH and FINISH; a FETCH stall SHALL produce no sclk edges.
REQ-028 FINISH: done=1 for one cycle, ssel_out=0, -> IDLE.
REQ-029 Exactly 8*NBYTES rising sclk_out edges SHALL occur per load.
REQ-030 All outputs SHALL be registered; sclk_out, ssel_out and sin_out SHALL be glitch-free.

Reset
REQ-031 Reset SHALL force IDLE, with sclk_out, ssel_out, sin_out, byte_ready, rb_valid, busy and done all 0, rb_byte=0x00, and all counters cleared.
REQ-032 Reset mid-load SHALL abort immediately with no further sclk_out edges; the buffer holds a partial pattern and a new start reloads it completely.

Structure
REQ-033 The state encoding and the NBYTES and HALF defaults SHALL live in a shared package, pattern_pkg.
REQ-034 One sub-module, sclk_divider (HALF-cycle phase counter producing phase-end ticks), SHALL be used; all other logic is flat.

Verification
REQ-035 Reset, then start, feeding bytes 0x00..0x1A with no stall -> 216 sclk edges; buffer byte i=0x1A-i; done pulses once; ssel low afterwards.
REQ-036 Preload buffer byte i=0xA0+i, then load all 0x55 -> rb_byte sequence 0xBA,0xB9,...,0xA0 with 27 rb_valid pulses; buffer all 0x55.
REQ-037 byte_valid held low for 10 cycles before byte 5 -> sclk_out low and no edges during the stall; final contents identical to the no-stall case.
REQ-038 Assert reset after 100 sclk edges -> all outputs 0 in the same cycle; a subsequent full load yields the correct pattern.
REQ-039 HALF=1 and HALF=4 -> sclk_out period 2 and 8 clk cycles; sin_out never changes while sclk_out=1.
REQ-040 start pulsed while busy -> ignored; edge count and done timing unchanged.
